// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op encodings (MDU_NOP .. MDU_MSUBU), 4 bits wide.
//   - Op-class helpers is_mul / is_div. Decode uses them to pick the busy-window length.
//   - FSM state type for the mdu top.
// Configuration macro: MDU_MADD_EN. When it is defined, the MADD/MADDU/MSUB/MSUBU ops
// are multiply-class ops. When it is undefined, the unit treats them as undefined ops.
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] MDU_NOP   = 4'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd7;
  localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd8;
  localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd9;
  localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Multiply-class ops: these use the MUL_LAT window.
  function automatic logic is_mul(input logic [MDU_OP_W-1:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  // Divide ops: these use the DIV_LAT window.
  function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational datapath of the multiply/divide unit.
// Ports:
//   op     in  4        latched operation
//   a1     in  WIDTH    latched rs operand
//   a2     in  WIDTH    latched rt operand
//   hi     in  WIDTH    current HI register (accumulate input and hold value)
//   lo     in  WIDTH    current LO register
//   result out 2*WIDTH  new {HI,LO}. It equals {hi,lo} for a divide by zero.
// Configuration macro: MDU_MADD_EN. When it is defined, the accumulate adder/subtractor
// is built.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MDU_OP_W-1:0]  op,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     a2,
  input  logic [WIDTH-1:0]     hi,
  input  logic [WIDTH-1:0]     lo,
  output logic [2*WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] hilo;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_signed;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign hilo = {hi, lo};

  // The low 2*WIDTH bits of the product of the sign-extended operands equal the
  // two's-complement signed product. This lets one unsigned multiplier shape serve
  // both forms.
  assign prod_s = {{WIDTH{a1[WIDTH-1]}}, a1} * {{WIDTH{a2[WIDTH-1]}}, a2};
  assign prod_u = {{WIDTH{1'b0}}, a1} * {{WIDTH{1'b0}}, a2};

  // Signed divide works on magnitudes and then applies the signs. -2^(WIDTH-1) keeps
  // its bit pattern as the magnitude 2^(WIDTH-1), so dividing it by -1 gives the
  // quotient -2^(WIDTH-1) and the remainder 0.
  assign div_signed = (op == MDU_DIV);
  assign neg_a      = div_signed & a1[WIDTH-1];
  assign neg_b      = div_signed & a2[WIDTH-1];
  assign mag_a      = neg_a ? -a1 : a1;
  assign mag_b      = neg_b ? -a2 : a2;
  assign q_mag      = (mag_b == '0) ? '0 : mag_a / mag_b;
  assign r_mag      = (mag_b == '0) ? '0 : mag_a % mag_b;
  assign quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
  assign rem        = neg_a ? -r_mag : r_mag;

  // NOTE: result gets its hold value before the case statement, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    result = hilo;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV,
      MDU_DIVU:  if (a2 != '0) result = {rem, quot};
`ifdef MDU_MADD_EN
      MDU_MADD:  result = hilo + prod_s;
      MDU_MADDU: result = hilo + prod_u;
      MDU_MSUB:  result = hilo - prod_s;
      MDU_MSUBU: result = hilo - prod_u;
`endif
      default:   result = hilo;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit with the architectural HI/LO registers.
// Ports:
//   clk     in  1      clock; all state updates on the rising edge
//   reset   in  1      synchronous, active-high
//   start   in  1      one-cycle request; mdu_op/A1/A2 are sampled with it
//   mdu_op  in  4      operation (mdu_pkg encodings)
//   A1      in  WIDTH  rs operand
//   A2      in  WIDTH  rt operand
//   busy    out 1      registered; high while an operation is in flight
//   hi      out WIDTH  HI register
//   lo      out WIDTH  LO register
// Configuration macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic [WIDTH-1:0]    A1,
  input  logic [WIDTH-1:0]    A2,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [WIDTH-1:0]    a1_q, a1_d;
  logic [WIDTH-1:0]    a2_q, a2_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [2*WIDTH-1:0]  result;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op     (op_q),
    .a1     (a1_q),
    .a2     (a2_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (result)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul(mdu_op) || is_div(mdu_op)) begin
            op_d    = mdu_op;
            a1_d    = A1;
            a2_d    = A2;
            cnt_d   = is_div(mdu_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            state_d = ST_BUSY;
          end else if (mdu_op == MDU_MTHI) begin
            hi_d = A1;
          end else if (mdu_op == MDU_MTLO) begin
            lo_d = A1;
          end
        end
      end
      ST_BUSY: begin
        // start is ignored here. Decode never issues while busy.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = result;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      // NOTE: the latched op/operands need no functional reset. They are only read
      // in BUSY, which always follows a load. They are cleared anyway so that the
      // post-reset state is fully known.
      op_q    <= MDU_NOP;
      a1_q    <= '0;
      a2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// Directed steps cover the main scenarios, followed by randomized ops. Each op is
// checked against a reference model of HI/LO written from the arithmetic rules of
// each op.
module tb_mdu;
  import mdu_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic              clk;
  logic              reset;
  logic              start;
  logic [3:0]        mdu_op;
  logic [WIDTH-1:0]  A1;
  logic [WIDTH-1:0]  A2;
  logic              busy;
  logic [WIDTH-1:0]  hi;
  logic [WIDTH-1:0]  lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mdu_op (mdu_op),
    .A1     (A1),
    .A2     (A2),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model. It updates m_hi/m_lo as the finished op would and returns the
  // expected length of the busy window (0 if the op does not open a window).
  function automatic int model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    logic [63:0] acc;
    sa  = a;
    sb  = b;
    ps  = longint'(sa) * longint'(sb);
    pu  = {32'b0, a} * {32'b0, b};
    acc = {m_hi, m_lo};
    case (op)
      4'd1: begin {m_hi, m_lo} = ps; return MUL_LAT; end
      4'd2: begin {m_hi, m_lo} = pu; return MUL_LAT; end
      4'd3: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'h0;
          end else begin
            m_lo = sa / sb;
            m_hi = sa % sb;
          end
        end
        return DIV_LAT;
      end
      4'd4: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        return DIV_LAT;
      end
      4'd5: begin m_hi = a; return 0; end
      4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd7:  begin {m_hi, m_lo} = acc + ps; return MUL_LAT; end
      4'd8:  begin {m_hi, m_lo} = acc + pu; return MUL_LAT; end
      4'd9:  begin {m_hi, m_lo} = acc - ps; return MUL_LAT; end
      4'd10: begin {m_hi, m_lo} = acc - pu; return MUL_LAT; end
`endif
      default: return 0;
    endcase
  endfunction

  // Issues one op and counts the busy cycles. It then checks the window length, that
  // busy has fallen, and the resulting HI/LO. With inject set, a DIV start is pulsed
  // in the second busy cycle. That start must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int exp_lat;
    int n;
    exp_lat = model_exec(op, a, b);
    @(negedge clk);
    start = 1'b1; mdu_op = op; A1 = a; A2 = b;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NOP;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      if (inject && n == 2) begin
        start = 1'b1; mdu_op = MDU_DIV; A1 = 32'd100; A2 = 32'd7;
      end else begin
        start = 1'b0; mdu_op = MDU_NOP;
      end
      @(negedge clk);
    end
    start = 1'b0; mdu_op = MDU_NOP;
    check({tag, ".busy_cycles"}, 64'(n), 64'(exp_lat));
    check({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
    if (inject) begin
      @(negedge clk);
      check({tag, ".no_injected_op"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mdu_op = MDU_NOP; A1 = '0; A2 = '0;
    repeat (2) @(negedge clk);
    check("reset.busy", 64'(busy), 64'(0));
    check("reset.hi", 64'(hi), 64'(0));
    check("reset.lo", 64'(lo), 64'(0));
    reset = 1'b0;

    run_op("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_neg2x3.literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max_x2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("multu_max_x2.literal", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2.literal", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_by0", MDU_DIVU, 32'd1234, 32'd0, 1'b0);
    run_op("div_min_by_m1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mthi", MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    run_op("mtlo", MDU_MTLO, 32'h0, 32'd0, 1'b0);
`ifdef MDU_MADD_EN
    run_op("maddu", MDU_MADDU, 32'h0001_0000, 32'h0001_0000, 1'b0);
    check("maddu.literal", {hi, lo}, 64'h1234_5679_0000_0000);
    run_op("msub", MDU_MSUB, 32'hFFFF_FFFD, 32'd7, 1'b0);
`else
    run_op("madd_disabled", MDU_MADD, 32'h0001_0000, 32'h0001_0000, 1'b0);
    repeat (3) @(negedge clk);
    check("madd_disabled.busy_later", 64'(busy), 64'(0));
    check("madd_disabled.hilo_later", {hi, lo}, {m_hi, m_lo});
`endif
    run_op("mtlo_nz", MDU_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);

    // Abort a MULT with reset in its 3rd busy cycle.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; A1 = 32'd9; A2 = 32'd9;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NOP;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("abort.busy", 64'(busy), 64'(0));
    check("abort.hilo", {hi, lo}, 64'h0);
    repeat (8) @(negedge clk);
    check("abort.busy_later", 64'(busy), 64'(0));
    check("abort.no_commit", {hi, lo}, 64'h0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      int          mode;
      op   = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 300) - 150; b = $urandom_range(1, 20); end
      run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the next-generation core.
- Accepts one operation per `start` pulse and holds `busy` for a fixed, parameter-set number of cycles.
- Commits the result to HI/LO at the end of that window.
- Upstream decode stalls on `busy | start` for any instruction that touches HI/LO; `hi`/`lo` feed the MFHI/MFLO forwarding path.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_LAT`, 5: busy cycles for multiply-class ops; must be ≥1.
- `DIV_LAT`, 10: busy cycles for divide ops; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request; op and operands are sampled with it.
- `mdu_op`  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
- `A1`  in  WIDTH  rs operand.
- `A2`  in  WIDTH  rt operand.
- `busy`  out  1  registered; high while an operation is in flight.
- `hi`  out  WIDTH  current HI register.
- `lo`  out  WIDTH  current LO register.

## Operation
- States: IDLE, BUSY. A down-counter of width clog2(max(MUL_LAT,DIV_LAT)+1) tracks the window.
- IDLE, `start` with a MULT/MULTU/MADD*/MSUB* op:
  - latch op and operands; counter = MUL_LAT; go to BUSY.
- IDLE, `start` with DIV/DIVU:
  - same behaviour, with counter = DIV_LAT.
- IDLE, `start` with MTHI/MTLO:
  - write `A1` into HI or LO at that edge; no busy window.
- IDLE, `start` with NOP or an undefined op:
  - ignored.
- BUSY:
  - counter decrements each cycle.
  - On the edge where the counter goes 1→0, the result commits to HI/LO and the unit returns to IDLE.
- `start` while `busy` is ignored entirely; decode guarantees this never happens.
- Arithmetic (2·WIDTH product, computed from the latched operands):
  - MULT: signed product; {HI,LO} = product.
  - MULTU: unsigned product; {HI,LO} = product.
  - MADD/MADDU: {HI,LO} += product (signed/unsigned), wrapping mod 2^(2·WIDTH).
  - MSUB/MSUBU: {HI,LO} −= product, wrapping.
  - Accumulate ops read the HI/LO values present at commit.
- DIV/DIVU:
  - LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - Divisor = 0: HI/LO are left unchanged, but the busy window still runs its full length.
  - Signed DIV of −2^(WIDTH−1) by −1: LO = −2^(WIDTH−1), HI = 0.
- HI/LO keep their old values throughout BUSY.

## Timing
- Reset: `busy`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `reset` asserted mid-operation aborts it: no commit, and all outputs take their reset values on the next edge.
- `start` sampled at edge E0:
  - `busy` is high in the cycles after E0, E1 … E(L−1), i.e. exactly L cycles, where L = MUL_LAT or DIV_LAT.
  - HI/LO carry the new values, and `busy`=0, from edge EL onward.
- A new `start` is accepted in the first cycle after `busy` falls, so back-to-back ops have a throughput of one per L+1 cycles.
- MTHI/MTLO: `hi`/`lo` update at the sampling edge; the new value is readable the next cycle; `busy` stays 0.

## Configuration
- Macro `MDU_MADD_EN`.
- Defined: ops 7–10 (MADD, MADDU, MSUB, MSUBU) are implemented as above.
- Undefined: ops 7–10 are treated as undefined. They are ignored, and no accumulate adder is built.

## Structure
- Shared package `mdu_pkg`:
  - `mdu_op` encodings as named localparams (`MDU_NOP` … `MDU_MSUBU`);
  - the op-class helper `is_mul`/`is_div`.
- The core's decoder imports this package to drive `mdu_op`.
- One sub-module, `mdu_arith`: purely combinational, produces the 2·WIDTH result {HI,LO} from the latched op, operands, and current HI/LO. The `mdu` top holds the FSM, counter, and registers.

## Test plan
- Reset, then MULT A1=0xFFFFFFFE (−2), A2=3 → `busy` high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU A1=0xFFFFFFFF, A2=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 cycles. A `start` DIV issued during busy → no effect.
- DIV A1=−7, A2=2 → `busy` 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with A2=0 → 10 busy cycles, hi/lo unchanged.
- MTHI A1=0x12345678 → hi=0x12345678 next cycle, `busy` never asserted. With `MDU_MADD_EN`, follow with MADDU A1=A2=0x10000 → {hi,lo} = {0x12345679, 0x00000000}.
- Assert `reset` on the 3rd busy cycle of a MULT → `busy`=0 and hi=lo=0 next cycle; no later commit.
- Without `MDU_MADD_EN`: MADD with `start` → `busy` stays 0, hi/lo unchanged.
